uart_rx_ctrl: RTL

Frame controller for the UART receive path. It detects the start bit, runs the per-bit oversampling edge counter and bit counter, and drives the data sampler. It deserializes data bits LSB-first, pulses the parity checker's enable and consumes its par_err result. It checks start and stop bits and issues a one-cycle data_valid for each clean frame.

---
 rtl/uart_rx_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, oversampling edge/bit counting,
// LSB-first deserialization, parity strobe and start/stop/parity frame checking.
module uart_rx_ctrl #(
  parameter int DATA_W = 8,
  parameter int EDGE_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [EDGE_W-1:0] prescale,
  input  logic              par_en,
  input  logic              sampled_bit,
  input  logic              par_err,
  output logic              dat_samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              par_check_en,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              stop_err
);

  localparam int                BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [EDGE_W-1:0] EDGE_ZERO = EDGE_W'(0);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHK    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [EDGE_W-1:0] edge_cnt_r;
  logic [EDGE_W-1:0] edge_nxt_s;
  logic [EDGE_W-1:0] edge_inc_s;
  logic [EDGE_W-1:0] last_edge_s;
  logic [EDGE_W-1:0] prescale_r;
  logic [BIT_W-1:0]  bit_idx_r;
  logic [BIT_W-1:0]  bit_idx_nxt_s;
  logic              par_en_r;
  logic              bit_end_s;
  logic              frame_start_s;
  logic              capture_s;
  logic              stop_end_s;
  logic [DATA_W-1:0] p_data_r;
  logic              dat_samp_en_r;
  logic              par_check_en_r;
  logic              data_valid_r;
  logic              stop_err_r;
  logic              samp_en_nxt_s;
  logic              pce_nxt_s;
  logic              dv_nxt_s;

  // Bit time ends on the last oversampling edge of the latched prescale.
  assign last_edge_s = prescale_r - EDGE_ONE;
  assign bit_end_s   = (edge_cnt_r == last_edge_s);
  assign edge_inc_s  = edge_cnt_r + EDGE_ONE;

  // Next-state, edge counter and bit index decode.
  always_comb begin
    state_nxt_s   = state_r;
    edge_nxt_s    = EDGE_ZERO;
    bit_idx_nxt_s = bit_idx_r;
    frame_start_s = 1'b0;
    capture_s     = 1'b0;
    stop_end_s    = 1'b0;
    case (state_r)
      IDLE, CHK: begin
        // A low line in IDLE or CHK is edge 0 of the next start bit.
        bit_idx_nxt_s = BIT_ZERO;
        if (!RX_IN) begin
          state_nxt_s   = START;
          edge_nxt_s    = EDGE_ONE;
          frame_start_s = 1'b1;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          if (!sampled_bit) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          edge_nxt_s = edge_inc_s;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          capture_s = 1'b1;
          if (bit_idx_r == BIT_LAST) begin
            bit_idx_nxt_s = BIT_ZERO;
            if (par_en_r) begin
              state_nxt_s = PARITY;
            end else begin
              state_nxt_s = STOP;
            end
          end else begin
            bit_idx_nxt_s = bit_idx_r + BIT_ONE;
          end
        end else begin
          edge_nxt_s = edge_inc_s;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = STOP;
        end else begin
          edge_nxt_s = edge_inc_s;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          stop_end_s  = 1'b1;
          state_nxt_s = CHK;
        end else begin
          edge_nxt_s = edge_inc_s;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        bit_idx_nxt_s = BIT_ZERO;
      end
    endcase
  end

  // Output decode one cycle ahead so every output comes straight from a flop.
  always_comb begin
    samp_en_nxt_s = 1'b0;
    pce_nxt_s     = 1'b0;
    dv_nxt_s      = 1'b0;
    case (state_nxt_s)
      START, DATA, STOP: begin
        samp_en_nxt_s = 1'b1;
      end
      PARITY: begin
        samp_en_nxt_s = 1'b1;
        pce_nxt_s     = (edge_nxt_s == last_edge_s);
      end
      CHK: begin
        // par_err is already settled during STOP, so the verdict can be taken here.
        dv_nxt_s = stop_end_s & sampled_bit & (~par_en_r | ~par_err);
      end
      default: begin
        samp_en_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, edge counter and bit index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      edge_cnt_r <= EDGE_ZERO;
      bit_idx_r  <= BIT_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      edge_cnt_r <= edge_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
    end
  end

  // Frame configuration is frozen at the start of each frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_r <= EDGE_ZERO;
      par_en_r   <= 1'b0;
    end else if (frame_start_s) begin
      prescale_r <= prescale;
      par_en_r   <= par_en;
    end
  end

  // Data shift-in and stop-bit error flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_r   <= {DATA_W{1'b0}};
      stop_err_r <= 1'b0;
    end else begin
      if (capture_s) begin
        p_data_r[bit_idx_r] <= sampled_bit;
      end
      if (frame_start_s) begin
        stop_err_r <= 1'b0;
      end else if (stop_end_s) begin
        stop_err_r <= ~sampled_bit;
      end
    end
  end

  // Registered strobes and enables.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dat_samp_en_r  <= 1'b0;
      par_check_en_r <= 1'b0;
      data_valid_r   <= 1'b0;
    end else begin
      dat_samp_en_r  <= samp_en_nxt_s;
      par_check_en_r <= pce_nxt_s;
      data_valid_r   <= dv_nxt_s;
    end
  end

  assign dat_samp_en  = dat_samp_en_r;
  assign edge_cnt     = edge_cnt_r;
  assign par_check_en = par_check_en_r;
  assign p_data       = p_data_r;
  assign data_valid   = data_valid_r;
  assign stop_err     = stop_err_r;

endmodule
